// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - client request/ack bundle plus memory port for mem_access_arbiter
// Ports (slave = arbiter view):
//   req/req_wr/req_addr/req_wdata  in   per-client request, op, address, write data (client i at slice i)
//   req_ack/rsp_rdata              out  one-cycle completion pulse per client, read data valid with ack
//   gnt_id/busy/init_done          out  client being served, non-idle flag, clear sweep finished
//   mem_wr_rd/mem_addr/mem_din     out  single-port memory control/address/write data
//   mem_dout                       in   registered memory read data
interface mem_access_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
) ();
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ack;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [2:0]                gnt_id;
    logic                      busy;
    logic                      init_done;
    logic                      mem_wr_rd;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_din;
    logic [DATA_W-1:0]         mem_dout;

    modport slave (
        input  req, req_wr, req_addr, req_wdata, mem_dout,
        output req_ack, rsp_rdata, gnt_id, busy, init_done, mem_wr_rd, mem_addr, mem_din
    );

    modport master (
        output req, req_wr, req_addr, req_wdata, mem_dout,
        input  req_ack, rsp_rdata, gnt_id, busy, init_done, mem_wr_rd, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin arbiter sharing one single-port memory among NUM_REQ clients
// Ports:
//   i_clk  in  single clock, all logic on posedge
//   i_rst  in  synchronous active-high reset
//   bus    mem_access_arbiter_if.slave: client req/ack handshake and memory port
// Every output is a register loaded from the next-state logic, so the registered
// outputs always describe the state the FSM is currently in.
module mem_access_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 6,
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mem_access_arbiter_if.slave bus
);
    localparam int         CNT_W    = ADDR_W + 1;
    localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);
    localparam logic       CLEAR    = (CLEAR_ON_RESET != 0);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [NUM_REQ-1:0]  r_ack, w_ack;
    logic [DATA_W-1:0]   r_rdata, w_rdata;
    logic [2:0]          r_gnt, w_gnt;
    logic [2:0]          r_last, w_last;
    logic                r_busy, r_init_done;
    logic                r_mem_wr_rd, w_mem_wr_rd;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0]   r_mem_din, w_mem_din;

    logic                w_found;
    logic [2:0]          w_win;
    logic                w_win_wr;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic [NUM_REQ-1:0]  w_gnt_onehot;

    // Round-robin search: try distances 1..NUM_REQ after the last grant, first set request wins.
    always_comb begin : arbitrate
        w_found     = 1'b0;
        w_win       = r_last;
        w_win_wr    = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && bus.req[i] && (i == (int'(r_last) + k) % NUM_REQ)) begin
                    w_found     = 1'b1;
                    w_win       = 3'(i);
                    w_win_wr    = bus.req_wr[i];
                    w_win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                    w_win_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin : gnt_decode
        w_gnt_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt_onehot[i] = (r_gnt == 3'(i));
        end
    end

    always_comb begin : next_state
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_ack       = '0;
        w_rdata     = r_rdata;
        w_gnt       = r_gnt;
        w_last      = r_last;
        w_mem_wr_rd = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_din   = r_mem_din;
        case (r_state)
            S_INIT: begin
                // r_cnt is the next address to clear; it reaches DEPTH once the last write is on the port.
                if (r_cnt == CNT_W'(DEPTH)) begin
                    w_state    = S_IDLE;
                    w_mem_addr = '0;
                    w_mem_din  = '0;
                end else begin
                    w_mem_wr_rd = 1'b1;
                    w_mem_addr  = r_cnt[ADDR_W-1:0];
                    w_mem_din   = '0;
                    w_cnt       = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                w_mem_addr = '0;
                w_mem_din  = '0;
                if (w_found) begin
                    w_state     = S_ISSUE;
                    w_gnt       = w_win;
                    w_last      = w_win;
                    w_mem_wr_rd = w_win_wr;
                    w_mem_addr  = w_win_addr;
                    w_mem_din   = w_win_wdata;
                end
            end
            S_ISSUE: begin
                // r_mem_wr_rd still holds the latched op of the winner during ISSUE.
                if (r_mem_wr_rd) begin
                    w_state = S_RESP;
                    w_ack   = w_gnt_onehot;
                end else begin
                    w_state = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                w_rdata = bus.mem_dout;
                w_state = S_RESP;
                w_ack   = w_gnt_onehot;
            end
            S_RESP: begin
                w_state    = S_IDLE;
                w_mem_addr = '0;
                w_mem_din  = '0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= CLEAR ? S_INIT : S_IDLE;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_gnt       <= '0;
            r_last      <= LAST_RST;
            r_busy      <= CLEAR;
            r_init_done <= 1'b0;
            r_mem_wr_rd <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_ack       <= w_ack;
            r_rdata     <= w_rdata;
            r_gnt       <= w_gnt;
            r_last      <= w_last;
            r_busy      <= (w_state != S_IDLE);
            r_init_done <= r_init_done | (w_state == S_IDLE);
            r_mem_wr_rd <= w_mem_wr_rd;
            r_mem_addr  <= w_mem_addr;
            r_mem_din   <= w_mem_din;
        end
    end

    assign bus.req_ack   = r_ack;
    assign bus.rsp_rdata = r_rdata;
    assign bus.gnt_id    = r_gnt;
    assign bus.busy      = r_busy;
    assign bus.init_done = r_init_done;
    assign bus.mem_wr_rd = r_mem_wr_rd;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_din   = r_mem_din;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - scoreboard bench for mem_access_arbiter with a transaction-level model
module tb_mem_access_arbiter;
    localparam int NR = 2;
    localparam int AW = 6;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    mem_access_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
    mem_access_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

    mem_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .DEPTH(64), .CLEAR_ON_RESET(1))
        dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a.slave));
    mem_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .DEPTH(64), .CLEAR_ON_RESET(0))
        dut_b (.i_clk(clk), .i_rst(rst_b), .bus(bus_b.slave));

    // 64x8 single-port memories with registered read
    logic [DW-1:0] mem_a [64];
    logic [DW-1:0] mem_b [64];
    always @(posedge clk) begin
        if (bus_a.mem_wr_rd) mem_a[bus_a.mem_addr] <= bus_a.mem_din;
        bus_a.mem_dout <= mem_a[bus_a.mem_addr];
        if (bus_b.mem_wr_rd) mem_b[bus_b.mem_addr] <= bus_b.mem_din;
        bus_b.mem_dout <= mem_b[bus_b.mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {bit wr; int addr; int data;} op_t;
    typedef struct {int cyc; int client; bit wr; int rdata;} exp_t;

    op_t  dq[NR][$];
    exp_t exp_q[$];
    exp_t mon_e;
    int   ref_mem [64];
    int   m_last;
    int   last_rd;

    // Monitor: every ack pops one expected completion
    always @(negedge clk) begin
        if (bus_a.req_ack != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", int'(bus_a.req_ack), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_onehot", int'(bus_a.req_ack), 1 << mon_e.client);
                chk("gnt_id", int'(bus_a.gnt_id), mon_e.client);
                chk("ack_cycle", cyc, mon_e.cyc);
                if (!mon_e.wr) begin
                    chk("read_data", int'(bus_a.rsp_rdata), mon_e.rdata);
                    last_rd = mon_e.rdata;
                end else begin
                    chk("rdata_hold_on_write", int'(bus_a.rsp_rdata), last_rd);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            chk("missing_ack", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
    end

    task automatic reset_model();
        for (int i = 0; i < 64; i++) ref_mem[i] = 0;
        m_last  = NR - 1;
        last_rd = 0;
    endtask

    task automatic add_op(int c, int wr, int addr, int data);
        op_t o;
        o.wr   = (wr != 0);
        o.addr = addr;
        o.data = data;
        dq[c].push_back(o);
    endtask

    function automatic bit pending();
        for (int i = 0; i < NR; i++) if (dq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic present();
        for (int i = 0; i < NR; i++) begin
            if (dq[i].size() > 0) begin
                bus_a.req[i]                = 1'b1;
                bus_a.req_wr[i]             = dq[i][0].wr;
                bus_a.req_addr[i*AW +: AW]  = AW'(dq[i][0].addr);
                bus_a.req_wdata[i*DW +: DW] = DW'(dq[i][0].data);
            end else begin
                bus_a.req[i] = 1'b0;
            end
        end
    endtask

    // Model: service pending clients round-robin, write = 3 cycles, read = 4 cycles, no gaps
    task automatic run_batch();
        op_t  mq[NR][$];
        op_t  op;
        exp_t e;
        int   t;
        int   c;
        int   tmo;
        for (int i = 0; i < NR; i++) mq[i] = dq[i];
        t = cyc;
        while (1) begin
            c = -1;
            for (int k = 1; k <= NR; k++)
                if (c < 0 && mq[(m_last + k) % NR].size() > 0) c = (m_last + k) % NR;
            if (c < 0) break;
            op       = mq[c].pop_front();
            e.client = c;
            e.wr     = op.wr;
            e.cyc    = t + (op.wr ? 2 : 3);
            if (op.wr) begin
                ref_mem[op.addr] = op.data;
                e.rdata = 0;
            end else begin
                e.rdata = ref_mem[op.addr];
            end
            exp_q.push_back(e);
            m_last = c;
            t      = e.cyc + 1;
        end
        present();
        tmo = 0;
        while (pending() && tmo < 300) begin
            @(negedge clk);
            tmo++;
            for (int i = 0; i < NR; i++)
                if (bus_a.req_ack[i] && dq[i].size() > 0) void'(dq[i].pop_front());
            present();
        end
        if (tmo >= 300) begin
            chk("batch_timeout", tmo, 0);
            for (int i = 0; i < NR; i++) dq[i].delete();
            bus_a.req = '0;
        end
    endtask

    function automatic int rnd_addr();
        case ($urandom_range(0, 3))
            0:       return 5;
            1:       return 63;
            2:       return int'($urandom_range(0, 3));
            default: return int'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic random_batch();
        int n;
        int tot = 0;
        for (int i = 0; i < NR; i++) begin
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++) begin
                add_op(i, int'($urandom_range(0, 1)), rnd_addr(), int'($urandom_range(0, 255)));
                tot++;
            end
        end
        if (tot == 0) add_op(NR - 1, 0, rnd_addr(), 0);
        run_batch();
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic gap();
        @(negedge clk);
    endtask

    // Entered in the first cycle after a reset edge with rst already released; both clients request throughout.
    task automatic sweep_check();
        bus_a.req      = '1;
        bus_a.req_wr   = '0;
        bus_a.req_addr = '0;
        chk("rst_busy", int'(bus_a.busy), 1);
        chk("rst_init_done", int'(bus_a.init_done), 0);
        chk("rst_mem_wr_rd", int'(bus_a.mem_wr_rd), 0);
        chk("rst_rdata", int'(bus_a.rsp_rdata), 0);
        chk("rst_gnt_id", int'(bus_a.gnt_id), 0);
        chk("rst_ack", int'(bus_a.req_ack), 0);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk("sweep_write",
                int'({bus_a.mem_wr_rd, bus_a.mem_addr, bus_a.mem_din, bus_a.req_ack, bus_a.init_done}),
                int'({1'b1, 6'(k), 8'h00, 2'b00, 1'b0}));
            if (k == 63) bus_a.req = '0;
        end
        @(negedge clk);
        chk("init_done_rise", int'(bus_a.init_done), 1);
        chk("idle_busy", int'(bus_a.busy), 0);
        chk("idle_mem_wr_rd", int'(bus_a.mem_wr_rd), 0);
        reset_model();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem_a[i] = 8'hCC;
        bus_a.req = '0; bus_a.req_wr = '0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
        bus_b.req = '0; bus_b.req_wr = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
        reset_model();
        repeat (3) @(negedge clk);

        // CLEAR_ON_RESET=0 instance: no sweep, client 1 write acked in third cycle
        rst_b = 1'b0;
        chk("b_rst_init_done", int'(bus_b.init_done), 0);
        chk("b_rst_busy", int'(bus_b.busy), 0);
        @(negedge clk);
        chk("b_init_done", int'(bus_b.init_done), 1);
        chk("b_busy", int'(bus_b.busy), 0);
        bus_b.req                = 2'b10;
        bus_b.req_wr             = 2'b10;
        bus_b.req_addr[AW +: AW] = 6'h07;
        bus_b.req_wdata[DW +: DW] = 8'h3C;
        @(negedge clk);
        chk("b_issue", int'({bus_b.req_ack, bus_b.mem_wr_rd, bus_b.mem_addr, bus_b.mem_din}),
            int'({2'b00, 1'b1, 6'h07, 8'h3C}));
        @(negedge clk);
        chk("b_ack", int'(bus_b.req_ack), 2);
        chk("b_gnt_id", int'(bus_b.gnt_id), 1);
        bus_b.req = '0;
        @(negedge clk);
        chk("b_ack_pulse", int'(bus_b.req_ack), 0);
        chk("b_idle_busy", int'(bus_b.busy), 0);

        // Main instance: sweep with both clients requesting
        rst = 1'b0;
        sweep_check();

        add_op(0, 1, 5, 8'hA5); run_batch(); gap();
        add_op(0, 0, 5, 0);     run_batch(); gap();
        add_op(1, 0, 63, 0);    run_batch(); gap();
        add_op(0, 0, 16, 0); add_op(0, 0, 16, 0);
        add_op(1, 1, 63, 8'h5A); add_op(1, 1, 63, 8'h5A);
        run_batch(); gap();
        add_op(0, 1, 63, 8'hFF); run_batch(); gap();
        add_op(1, 0, 63, 0);     run_batch(); gap();

        for (int b = 0; b < 40; b++) random_batch();

        // Reset during RD_WAIT of an unscored read
        add_op(0, 1, 5, 8'hA5); run_batch(); gap();
        add_op(0, 0, 5, 0);     run_batch(); gap();
        bus_a.req            = 2'b01;
        bus_a.req_wr         = 2'b00;
        bus_a.req_addr[0 +: AW] = 6'h05;
        @(negedge clk);
        @(negedge clk);
        chk("rdwait_busy", int'(bus_a.busy), 1);
        chk("rdwait_addr", int'({bus_a.mem_wr_rd, bus_a.mem_addr}), int'({1'b0, 6'h05}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sweep_check();

        add_op(0, 0, 5, 0); add_op(1, 0, 63, 0); run_batch(); gap();
        for (int b = 0; b < 10; b++) random_batch();

        repeat (6) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
Single-clock controller that shares one 64x8 single-port memory (wr_rd/addr/data_in/data_out interface, registered read) among NUM_REQ requesters. It runs a round-robin req/ack handshake, sequences each write or read onto the memory port, and returns read data. After reset it optionally sweeps the memory to zero before accepting traffic. Sits between client blocks and the memory instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 6, memory address width
DATA_W, 8, memory data width
DEPTH, 64, words cleared by the init sweep (= 2**ADDR_W)
CLEAR_ON_RESET, 1, 1 = zero-fill memory after reset; 0 = go straight to IDLE

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  request per client, held until ack
req_wr  input  NUM_REQ  per client: 1 = write, 0 = read
req_addr  input  NUM_REQ*ADDR_W  client i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  client i at [i*DATA_W +: DATA_W]
req_ack  output  NUM_REQ  one-cycle completion pulse to winner
rsp_rdata  output  DATA_W  read data, valid while req_ack high for a read
gnt_id  output  3  index of client currently served
busy  output  1  high in any state other than IDLE
init_done  output  1  high once clear sweep finished (or immediately if CLEAR_ON_RESET=0)
mem_wr_rd  output  1  to memory wr_rd: 1 = write, 0 = read
mem_addr  output  ADDR_W  to memory addr
mem_din  output  DATA_W  to memory data_in
mem_dout  input  DATA_W  from memory data_out

Behaviour:
- All outputs registered. Reset values: req_ack=0, rsp_rdata=0, gnt_id=0, busy=1 if CLEAR_ON_RESET else 0, init_done=0, mem_wr_rd=0, mem_addr=0, mem_din=0; rr pointer = NUM_REQ-1 (client 0 has first priority).
- States: INIT, IDLE, ISSUE, RD_WAIT, RESP.
- INIT: init counter 0..DEPTH-1, one write per cycle (mem_wr_rd=1, mem_addr=counter, mem_din=0). After address DEPTH-1 -> IDLE; init_done=1 from first IDLE cycle, stays 1 until next rst. Requests ignored (no ack) in INIT.
- IDLE: mem_wr_rd=0, mem_addr=0. If any req: winner = first set bit searching from (last_gnt+1) mod NUM_REQ upward with wrap; latch winner's wr/addr/wdata, gnt_id=winner, last_gnt=winner -> ISSUE. No req -> stay.
- ISSUE (1 cycle): drive latched op on mem_wr_rd/mem_addr/mem_din. Write -> RESP; read -> RD_WAIT.
- RD_WAIT (1 cycle): mem_wr_rd=0, addr held; capture mem_dout into rsp_rdata at end of cycle -> RESP.
- RESP (1 cycle): req_ack[gnt_id]=1, all other ack bits 0; mem_wr_rd=0 -> IDLE.
- Latency from first IDLE cycle with req high to ack: write 3 cycles, read 4 cycles. Back-to-back throughput: one write per 3 cycles, one read per 4.
- Requester keeps req/wr/addr/wdata stable until ack; deasserts at the edge after ack. req still high in the IDLE cycle after ack = new request (arbitrated normally; rr pointer guarantees another pending client wins first).
- rsp_rdata holds last read value until next read completes; unchanged by writes.
- Requests arriving while busy wait; never dropped, never acked twice.
- rst in any state: immediate return to reset values, in-flight transaction abandoned with no ack, INIT restarts from address 0.
- Request inputs changing after latch in IDLE do not affect the current transaction.

Test Plan:
- CLEAR_ON_RESET=1, rst 1 cycle -> exactly 64 consecutive writes addr 0..63 data 0x00, init_done rises on cycle 65, no ack during sweep even with req=2'b11.
- Client 0 write addr 0x05 data 0xA5 -> ack[0] 3 cycles later; then client 0 read 0x05 -> ack[0] 4 cycles after request, rsp_rdata=0xA5.
- req=2'b11 held continuously, client0 reads 0x10, client1 writes 0x3F/0x5A -> grants alternate 0,1,0,1; each ack only to its own client.
- Read of uncleared-after-sweep address 0x3F -> rsp_rdata=0x00; write 0x3F=0xFF then read -> 0xFF (address wrap edge).
- rst asserted during RD_WAIT of a read -> no ack, busy=1, sweep restarts at addr 0, prior rsp_rdata cleared to 0x00.
- CLEAR_ON_RESET=0 -> init_done=1 and busy=0 on first cycle after rst; write from client 1 acked 3 cycles after req.
